// File: rtl/mem_io_ctrl.sv
// ============================================================================
// mem_io_ctrl : SRAM / memory-mapped switch+hex controller, fixed-wait FSM
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_io_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_out,
  output logic [15:0] Data_to_CPU,
  output logic        Data_valid,
  output logic        Busy,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        SRAM_OE,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic        UB_N,
  output logic        LB_N,
  input  logic [15:0] Switches,
  output logic [15:0] HEX_Data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        rw_q, rw_d;
  logic [15:0] cpu_q, cpu_d;
  logic [15:0] hex_q, hex_d;

  logic w_is_io;
  logic w_sram_access;

  assign w_is_io       = (mar_q == IO_ADDR);
  assign w_sram_access = (state_q == S_ACCESS) && !w_is_io;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      rw_q    <= 1'b0;
      cpu_q   <= 16'h0000;
      hex_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rw_q    <= rw_d;
      cpu_q   <= cpu_d;
      hex_q   <= hex_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rw_d    = rw_q;
    cpu_d   = cpu_q;
    hex_d   = hex_q;
    case (state_q)
      S_IDLE: begin
        if (MIO_EN) begin
          mar_d   = MAR;
          mdr_d   = MDR_out;
          rw_d    = R_W;
          cnt_d   = C_CNT_LOAD;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          // Completion side effects land on the same edge that enters DONE
          if (rw_q) begin
            if (w_is_io) hex_d = mdr_q;
          end else begin
            cpu_d = w_is_io ? Switches : Data_from_SRAM;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = MIO_EN ? S_RELEASE : S_IDLE;
      end
      S_RELEASE: begin
        if (!MIO_EN) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Busy         = (state_q == S_ACCESS) || (state_q == S_DONE);
  assign Data_valid   = (state_q == S_DONE);
  assign Data_to_CPU  = cpu_q;
  assign HEX_Data     = hex_q;
  assign ADDR         = {4'b0000, mar_q};
  assign Data_to_SRAM = mdr_q;

  assign CE_N    = ~w_sram_access;
  assign UB_N    = ~w_sram_access;
  assign LB_N    = ~w_sram_access;
  assign OE_N    = ~(w_sram_access & ~rw_q);
  assign WE_N    = ~(w_sram_access &  rw_q);
  assign SRAM_OE =   w_sram_access &  rw_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_io_ctrl.sv
// ============================================================================
// tb_mem_io_ctrl : table-driven, scoreboarded bench for mem_io_ctrl
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_io_ctrl;

  localparam int WAIT = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MIO_EN = 1'b0;
  logic        R_W = 1'b0;
  logic [15:0] MAR = 16'h0000;
  logic [15:0] MDR_out = 16'h0000;
  logic [15:0] Data_to_CPU;
  logic        Data_valid;
  logic        Busy;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM = 16'h0000;
  logic        SRAM_OE, CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [15:0] Switches = 16'h0000;
  logic [15:0] HEX_Data;

  mem_io_ctrl #(.WAIT_CYCLES(WAIT), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR),
    .MDR_out(MDR_out), .Data_to_CPU(Data_to_CPU), .Data_valid(Data_valid),
    .Busy(Busy), .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM),
    .Data_from_SRAM(Data_from_SRAM), .SRAM_OE(SRAM_OE), .CE_N(CE_N),
    .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
    .Switches(Switches), .HEX_Data(HEX_Data)
  );

  always #5 Clk = ~Clk;

  // {SRAM_OE, CE_N, OE_N, WE_N, UB_N, LB_N}
  localparam logic [5:0] STB_IDLE  = 6'b011111;
  localparam logic [5:0] STB_READ  = 6'b000100;
  localparam logic [5:0] STB_WRITE = 6'b101000;

  typedef struct {
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        rw;
    logic [15:0] sram;
    logic [15:0] sw;
    logic [5:0]  stb;
    logic [15:0] exp_cpu;
    logic [15:0] exp_hex;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {SRAM_OE, CE_N, OE_N, WE_N, UB_N, LB_N};
  endfunction

  // Every completion pulse must match the oldest outstanding expectation
  always @(posedge Clk) begin
    #1;
    if (Data_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got Data_valid=1, expected no pending transaction at %0t", $time);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("data_to_cpu", {16'h0, Data_to_CPU}, {16'h0, e[31:16]});
        chk("hex_data", {16'h0, HEX_Data}, {16'h0, e[15:0]});
      end
    end
  end

  task automatic run_txn(input vec_t v, input int hold);
    @(negedge Clk);
    MAR = v.mar; MDR_out = v.mdr; R_W = v.rw;
    Data_from_SRAM = v.sram; Switches = v.sw; MIO_EN = 1'b1;
    exp_q.push_back({v.exp_cpu, v.exp_hex});
    @(posedge Clk); #1;
    for (int k = 0; k < WAIT; k++) begin
      if (k > 0) begin @(posedge Clk); #1; end
      chk("access_strobes", {26'h0, strobes()}, {26'h0, v.stb});
      chk("access_addr", {12'h0, ADDR}, {16'h0, v.mar});
      chk("access_wdata", {16'h0, Data_to_SRAM}, {16'h0, v.mdr});
      chk("access_busy", {31'h0, Busy}, 32'd1);
      chk("access_no_valid", {31'h0, Data_valid}, 32'd0);
      if (k == 0) begin
        // Disturb the request inputs; the latched copies must win
        @(negedge Clk);
        MAR = v.mar ^ 16'h0030; MDR_out = ~v.mdr; R_W = ~v.rw;
      end
    end
    @(posedge Clk); #1;
    chk("done_valid", {31'h0, Data_valid}, 32'd1);
    chk("done_busy", {31'h0, Busy}, 32'd1);
    chk("done_strobes", {26'h0, strobes()}, {26'h0, STB_IDLE});
    for (int k = 0; k < hold; k++) begin
      @(posedge Clk); #1;
      chk("release_busy", {31'h0, Busy}, 32'd0);
      chk("release_no_valid", {31'h0, Data_valid}, 32'd0);
      chk("release_strobes", {26'h0, strobes()}, {26'h0, STB_IDLE});
    end
    @(negedge Clk); MIO_EN = 1'b0;
    @(posedge Clk); #1;
    chk("idle_busy", {31'h0, Busy}, 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'h0042, 16'h0000, 1'b0, 16'hBEEF, 16'h0000, STB_READ,  16'hBEEF, 16'h0000};
    tbl[1] = '{16'h1234, 16'h5A5A, 1'b1, 16'h1111, 16'h0000, STB_WRITE, 16'hBEEF, 16'h0000};
    tbl[2] = '{16'hFFFF, 16'h0000, 1'b0, 16'h2222, 16'h00C3, STB_IDLE,  16'h00C3, 16'h0000};
    tbl[3] = '{16'hFFFF, 16'h0007, 1'b1, 16'h3333, 16'h00AA, STB_IDLE,  16'h00C3, 16'h0007};
    tbl[4] = '{16'h0010, 16'hA5A5, 1'b1, 16'h4444, 16'h0000, STB_WRITE, 16'h00C3, 16'h0007};
    tbl[5] = '{16'h8000, 16'h0000, 1'b0, 16'h1357, 16'h0000, STB_READ,  16'h1357, 16'h0007};

    // Reset state, sampled while Reset is still high
    #2;
    chk("rst_strobes", {26'h0, strobes()}, {26'h0, STB_IDLE});
    chk("rst_busy_valid", {30'h0, Busy, Data_valid}, 32'd0);
    chk("rst_outputs", {Data_to_CPU, HEX_Data}, 32'd0);
    chk("rst_addr", {12'h0, ADDR}, 32'd0);
    @(negedge Clk); Reset = 1'b0;

    // Reset mid-access of an I/O write aborts it without side effects
    @(negedge Clk);
    MAR = 16'hFFFF; MDR_out = 16'h0055; R_W = 1'b1; MIO_EN = 1'b1;
    @(posedge Clk); #1;
    chk("abort_busy_before", {31'h0, Busy}, 32'd1);
    chk("abort_addr_before", {12'h0, ADDR}, 32'h0FFFF);
    #2; Reset = 1'b1; #1;
    chk("abort_busy", {31'h0, Busy}, 32'd0);
    chk("abort_valid", {31'h0, Data_valid}, 32'd0);
    chk("abort_strobes", {26'h0, strobes()}, {26'h0, STB_IDLE});
    chk("abort_addr", {12'h0, ADDR}, 32'd0);
    chk("abort_wdata", {16'h0, Data_to_SRAM}, 32'd0);
    MIO_EN = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(posedge Clk); #1;
    chk("abort_hex", {16'h0, HEX_Data}, 32'd0);
    chk("abort_cpu", {16'h0, Data_to_CPU}, 32'd0);
    chk("abort_no_pulse", n_pulses, 32'd0);

    // First entry holds MIO_EN long (no retrigger), the rest are short
    for (int i = 0; i < 6; i++) begin
      run_txn(tbl[i], (i == 0) ? 6 : 1);
      chk("pulse_count", n_pulses, i + 1);
    end

    // Values persist across idle cycles
    repeat (4) @(posedge Clk); #1;
    chk("hold_cpu", {16'h0, Data_to_CPU}, 32'h1357);
    chk("hold_hex", {16'h0, HEX_Data}, 32'h0007);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("total_pulses", n_pulses, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving SRAM access cycles per transaction; legal range 1..15.
REQ-002 SHALL have parameter IO_ADDR, default 16'hFFFF, giving the memory-mapped switch/hex I/O address.
REQ-003 SHALL have one clock and an asynchronous, active-high reset:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous active-high reset.
REQ-004 SHALL have these datapath and control ports:
- MIO_EN  in  1  memory request from the control unit.
- R_W  in  1  transfer direction: 1 = write, 0 = read.
- MAR  in  16  access address.
- MDR_out  in  16  write data from MDR.
- Data_to_CPU  out  16  read data, registered.
- Data_valid  out  1  one-cycle completion pulse.
- Busy  out  1  transaction in progress.
REQ-005 SHALL have these SRAM ports:
- ADDR  out  20  SRAM address, {4'b0, latched MAR}.
- Data_to_SRAM  out  16  latched write data.
- Data_from_SRAM  in  16  SRAM read data.
- SRAM_OE  out  1  drive enable for the external tristate.
- CE_N, OE_N, WE_N, UB_N, LB_N  out  1 each  SRAM strobes, active-low.
REQ-006 SHALL have these I/O ports:
- Switches  in  16  board switches.
- HEX_Data  out  16  hex display register.

Function
REQ-007 SHALL implement a four-state FSM: IDLE, ACCESS, DONE, RELEASE.
REQ-008 IDLE behaviour:
- Busy=0.
- On a rising edge with MIO_EN=1: latch MAR, MDR_out and R_W; load counter with WAIT_CYCLES-1; go to ACCESS.
- Otherwise stay in IDLE.
REQ-009 ACCESS behaviour:
- Busy=1.
- Counter decrements each edge.
- When counter==0, go to DONE on that edge.
- ACCESS therefore lasts exactly WAIT_CYCLES cycles.
REQ-010 SRAM strobes during ACCESS, when the latched address is not IO_ADDR:
- CE_N=UB_N=LB_N=0.
- Read: OE_N=0, WE_N=1.
- Write: WE_N=0, OE_N=1, SRAM_OE=1.
REQ-011 Outside ACCESS, and for IO_ADDR accesses, all strobes SHALL be 1 and SRAM_OE SHALL be 0.
REQ-012 On the ACCESS-to-DONE edge, the completing action SHALL be:
- SRAM read: Data_to_CPU <= Data_from_SRAM.
- IO_ADDR read: Data_to_CPU <= Switches.
- IO_ADDR write: HEX_Data <= latched write data.
- SRAM write: Data_to_CPU unchanged.
REQ-013 DONE behaviour:
- Data_valid=1 and Busy=1 for exactly one cycle.
- Next state is RELEASE if MIO_EN=1, else IDLE.
REQ-014 RELEASE behaviour:
- Busy=0.
- Stay until MIO_EN=0, then go to IDLE.
- A held MIO_EN SHALL never start a second transaction.
REQ-015 Latency: Data_valid SHALL rise WAIT_CYCLES edges after the sampling edge.
REQ-016 Changes to MAR, MDR_out or R_W after the sampling edge SHALL NOT affect the transaction in progress.
REQ-017 Data_to_CPU and HEX_Data SHALL hold their values between completions.

Reset
REQ-018 Reset=1 SHALL immediately, without waiting for a clock edge, force:
- state IDLE, counter 0.
- CE_N=OE_N=WE_N=UB_N=LB_N=1, SRAM_OE=0.
- Data_valid=0, Busy=0.
- Data_to_CPU=0, HEX_Data=0, ADDR=0, Data_to_SRAM=0.
REQ-019 Reset asserted during ACCESS SHALL abort the transaction with no completion pulse and no HEX_Data update.
REQ-020 After Reset deasserts, the first MIO_EN=1 edge SHALL start a fresh transaction.

Verification
REQ-021 The bench SHALL cover these directed scenarios (WAIT_CYCLES=2):
- SRAM read: MAR=0x0042, Data_from_SRAM=0xBEEF, R_W=0, MIO_EN held 3 cycles -> OE_N/CE_N low for exactly 2 cycles; Data_valid pulses on cycle 3; Data_to_CPU=0xBEEF; no retrigger.
- SRAM write: MAR=0x1234, MDR_out=0x5A5A, R_W=1 -> ADDR=0x01234, WE_N low for 2 cycles, SRAM_OE=1 in the same 2 cycles, Data_to_SRAM=0x5A5A.
- I/O read and write: MAR=0xFFFF, Switches=0x00C3, read -> Data_to_CPU=0x00C3, no strobes; then write 0x0007 -> HEX_Data=0x0007, no strobes.
- Held request: MIO_EN held high 10 cycles -> exactly one Data_valid pulse; the next transaction starts only after MIO_EN goes low then high.
- Reset mid-access: Reset asserted mid-ACCESS of an I/O write -> all strobes high, outputs zero, HEX_Data stays 0, no Data_valid.
- Input stability: MAR changed from 0x0010 to 0x0020 during ACCESS -> ADDR stays 0x00010 for the whole transaction.
